// File: rtl/es_pkg.sv
// es_pkg: address map, CTRL bit indices and default widths shared by the E/S responder
package es_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam logic [ADDR_W-1:0] ES_OUT0   = 7'h00;
  localparam logic [ADDR_W-1:0] ES_OUT1   = 7'h01;
  localparam logic [ADDR_W-1:0] ES_OUT2   = 7'h02;
  localparam logic [ADDR_W-1:0] ES_OUT3   = 7'h03;
  localparam logic [ADDR_W-1:0] ES_IN0    = 7'h04;
  localparam logic [ADDR_W-1:0] ES_IN1    = 7'h05;
  localparam logic [ADDR_W-1:0] ES_IN2    = 7'h06;
  localparam logic [ADDR_W-1:0] ES_IN3    = 7'h07;
  localparam logic [ADDR_W-1:0] ES_CTRL   = 7'h08;
  localparam logic [ADDR_W-1:0] ES_RELOAD = 7'h09;
  localparam logic [ADDR_W-1:0] ES_COUNT  = 7'h0A;
  localparam logic [ADDR_W-1:0] ES_PRESC  = 7'h0B;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLAG   = 7;
endpackage

// File: rtl/es_responder_if.sv
// es_responder_if: CPU data-memory port as seen by the E/S responder
interface es_responder_if #(
  parameter int DATA_W = es_pkg::DATA_W,
  parameter int ADDR_W = es_pkg::ADDR_W
);
  logic activar_es;
  logic escribir_es;
  logic [ADDR_W-1:0] direccion_es;
  logic [DATA_W-1:0] dato_entrada_es;
  logic [DATA_W-1:0] dato_salida_es;
  modport master(output activar_es, escribir_es, direccion_es, dato_entrada_es, input dato_salida_es);
  modport slave(input activar_es, escribir_es, direccion_es, dato_entrada_es, output dato_salida_es);
endinterface

// File: rtl/es_timer.sv
// es_timer: prescaled down-counter with auto-reload and interrupt flag (CTRL/RELOAD/COUNT/PRESC)
// Compiled only when ES_TIMER_EN is defined.
`ifdef ES_TIMER_EN
module es_timer import es_pkg::*; #(
  parameter int DATA_W = es_pkg::DATA_W,
  parameter int ADDR_W = es_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);
  logic en, autoRl, irqEn, flag;
  logic [DATA_W-1:0] reload, count, presc, pc, ctrl;
  logic ctrlWr, reloadWr, prescWr, tick, expire;
  always_comb begin
    ctrlWr   = wrEn && addr == ES_CTRL;
    reloadWr = wrEn && addr == ES_RELOAD;
    prescWr  = wrEn && addr == ES_PRESC;
    tick     = en && pc == presc && !reloadWr;
    expire   = tick && count == '0;
    ctrl = '0;
    ctrl[CTRL_EN]     = en;
    ctrl[CTRL_AUTO]   = autoRl;
    ctrl[CTRL_IRQ_EN] = irqEn;
    ctrl[CTRL_FLAG]   = flag;
    rdata = addr == ES_CTRL ? ctrl : addr == ES_RELOAD ? reload :
            addr == ES_COUNT ? count : addr == ES_PRESC ? presc : '0;
  end
  assign irq = flag && irqEn;
  always_ff @(posedge clk)
    if (reset) begin
      {en, autoRl, irqEn, flag} <= '0;
      {reload, count, presc, pc} <= '0;
    end else begin
      pc     <= (ctrlWr || reloadWr || tick) ? '0 : en ? pc + 1'b1 : pc;
      count  <= reloadWr ? wdata : !tick ? count : count != '0 ? count - 1'b1 : autoRl ? reload : count;
      reload <= reloadWr ? wdata : reload;
      presc  <= prescWr ? wdata : presc;
      // an expiry in the same cycle as a write-1-clear leaves FLAG set
      flag   <= expire || (flag && !(ctrlWr && wdata[CTRL_FLAG]));
      en     <= ctrlWr ? wdata[CTRL_EN] : (expire && !autoRl) ? 1'b0 : en;
      autoRl <= ctrlWr ? wdata[CTRL_AUTO] : autoRl;
      irqEn  <= ctrlWr ? wdata[CTRL_IRQ_EN] : irqEn;
    end
endmodule
`endif

// File: rtl/es_responder.sv
// es_responder: memory-mapped E/S device with 4 OUT registers, 4 synchronised IN ports and a timer
// Define ES_TIMER_EN to build the timer; otherwise 0x08-0x0B read 0 and irq is tied low.
module es_responder import es_pkg::*; #(
  parameter int DATA_W      = es_pkg::DATA_W,
  parameter int ADDR_W      = es_pkg::ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  es_responder_if.slave       bus,
  input  logic [4*DATA_W-1:0] entradas_ext,
  output logic [4*DATA_W-1:0] salidas_ext,
  output logic                irq
);
  logic [DATA_W-1:0] outReg [4];
  logic [4*DATA_W-1:0] syncQ [SYNC_STAGES];
  logic [DATA_W-1:0] timerRd, inByte;
  logic [1:0] sel;
  logic wrStb, rdStb;
  always_comb begin
    sel    = bus.direccion_es[1:0];
    wrStb  = bus.activar_es && bus.escribir_es;
    rdStb  = bus.activar_es && !bus.escribir_es;
    inByte = syncQ[SYNC_STAGES-1][sel*DATA_W +: DATA_W];
  end
  assign bus.dato_salida_es = !rdStb ? '0 :
                              bus.direccion_es < ES_IN0 ? outReg[sel] :
                              bus.direccion_es < ES_CTRL ? inByte :
                              bus.direccion_es <= ES_PRESC ? timerRd : '0;
  assign salidas_ext = {outReg[3], outReg[2], outReg[1], outReg[0]};
  always_ff @(posedge clk)
    if (reset) outReg <= '{default: '0};
    else if (wrStb && bus.direccion_es < ES_IN0) outReg[sel] <= bus.dato_entrada_es;
  always_ff @(posedge clk)
    if (reset) syncQ <= '{default: '0};
    else begin
      syncQ[0] <= entradas_ext;
      for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
`ifdef ES_TIMER_EN
  es_timer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) timer (
    .clk(clk),
    .reset(reset),
    .wrEn(wrStb),
    .addr(bus.direccion_es),
    .wdata(bus.dato_entrada_es),
    .rdata(timerRd),
    .irq(irq)
  );
`else
  assign timerRd = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_es_responder.sv
// tb_es_responder: scoreboard bench for es_responder (timer scenarios under ES_TIMER_EN)
module tb_es_responder;
  import es_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] entradas_ext = '0;
  logic [31:0] salidas_ext;
  logic irq;
  int vecs = 0;
  int errs = 0;
  logic [7:0] expQ [$];
  logic [7:0] got, exp;
  es_responder_if bus();
  es_responder dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .entradas_ext(entradas_ext),
    .salidas_ext(salidas_ext),
    .irq(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.activar_es = 1'b1;
    bus.escribir_es = 1'b1;
    bus.direccion_es = a;
    bus.dato_entrada_es = d;
  endtask
  task automatic rd(input logic [6:0] a);
    @(negedge clk);
    bus.activar_es = 1'b1;
    bus.escribir_es = 1'b0;
    bus.direccion_es = a;
    #2;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      expQ.push_back(8'h00);
      rd(7'(a));
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL reset_rd[%0h] got %h want %h", a, got, exp); end
    end
    vecs++;
    if (salidas_ext !== 32'h0 || irq !== 1'b0) begin
      errs++; $display("FAIL reset_outs got salidas=%h irq=%b want 0/0", salidas_ext, irq);
    end
  endtask
  task automatic test_out_regs;
    logic [7:0] want [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};
    wr(ES_OUT2, 8'hA5);
    expQ.push_back(8'hA5);
    rd(ES_OUT2);
    got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
    if (got !== exp) begin errs++; $display("FAIL out2_rd got %h want %h", got, exp); end
    vecs++;
    if (salidas_ext[23:16] !== 8'hA5) begin errs++; $display("FAIL out2_pin got %h want a5", salidas_ext[23:16]); end
    wr(ES_IN1, 8'h77);
    wr(7'h40, 8'h11);
    for (int a = 0; a < 4; a++) begin
      expQ.push_back(want[a]);
      rd(7'(a));
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL ro_write_out[%0d] got %h want %h", a, got, exp); end
    end
    expQ.push_back(8'h00);
    rd(ES_IN1);
    got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
    if (got !== exp) begin errs++; $display("FAIL ro_write_in1 got %h want %h", got, exp); end
    @(negedge clk);
    bus.activar_es = 1'b0;
    bus.direccion_es = ES_OUT2;
    #2;
    vecs++;
    if (bus.dato_salida_es !== 8'h00) begin errs++; $display("FAIL idle_rd got %h want 00", bus.dato_salida_es); end
    wr(ES_OUT2, 8'hA5);
    #2;
    vecs++;
    if (bus.dato_salida_es !== 8'h00) begin errs++; $display("FAIL wr_cycle_rd got %h want 00", bus.dato_salida_es); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] mdl [4];
    for (int i = 0; i < 4; i++) begin
      mdl[i] = 8'($urandom_range(1, 255));
      wr(7'(i), mdl[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      expQ.push_back(mdl[i]);
      rd(7'(i));
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL b2b_rd[%0d] got %h want %h", i, got, exp); end
    end
    vecs++;
    if (salidas_ext !== {mdl[3], mdl[2], mdl[1], mdl[0]}) begin
      errs++; $display("FAIL b2b_pins got %h want %h", salidas_ext, {mdl[3], mdl[2], mdl[1], mdl[0]});
    end
  endtask
  task automatic test_inputs;
    logic [7:0] vals [4] = '{8'h5E, 8'h3C, 8'hC3, 8'h81};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      entradas_ext[k*8 +: 8] = vals[k];
      bus.activar_es = 1'b1;
      bus.escribir_es = 1'b0;
      bus.direccion_es = 7'(ES_IN0 + k);
      expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(vals[k]); expQ.push_back(vals[k]);
      for (int c = 0; c < 4; c++) begin
        if (c > 0) rd(7'(ES_IN0 + k)); else #2;
        got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
        if (got !== exp) begin errs++; $display("FAIL in%0d_cyc%0d got %h want %h", k, c, got, exp); end
      end
    end
  endtask
`ifdef ES_TIMER_EN
  task automatic test_timer_auto;
    logic [7:0] cnt [10] = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd3, 8'd3};
    logic irqE [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [6:0] adr [4] = '{ES_CTRL, ES_CTRL, ES_COUNT, ES_COUNT};
    logic [7:0] val [4] = '{8'h87, 8'h07, 8'h01, 8'h00};
    wr(ES_PRESC, 8'd1);
    wr(ES_RELOAD, 8'd3);
    wr(ES_CTRL, 8'h07);
    for (int i = 0; i < 10; i++) begin
      expQ.push_back(cnt[i]);
      rd(ES_COUNT);
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL auto_count[%0d] got %h want %h", i, got, exp); end
      vecs++;
      if (irq !== irqE[i]) begin errs++; $display("FAIL auto_irq[%0d] got %b want %b", i, irq, irqE[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) wr(ES_CTRL, 8'h87);
      expQ.push_back(val[i]);
      rd(adr[i]);
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL auto_clear[%0d] got %h want %h", i, got, exp); end
    end
  endtask
  task automatic test_oneshot;
    wr(ES_CTRL, 8'h00);
    wr(ES_CTRL, 8'h80);
    wr(ES_PRESC, 8'd0);
    wr(ES_RELOAD, 8'd1);
    wr(ES_CTRL, 8'h01);
    expQ.push_back(8'h01); expQ.push_back(8'h01); expQ.push_back(8'h80);
    for (int i = 0; i < 3; i++) begin
      rd(ES_CTRL);
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL oneshot_ctrl[%0d] got %h want %h", i, got, exp); end
    end
    expQ.push_back(8'h00); expQ.push_back(8'h00);
    for (int i = 0; i < 2; i++) begin
      rd(ES_COUNT);
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL oneshot_count[%0d] got %h want %h", i, got, exp); end
    end
    vecs++;
    if (irq !== 1'b0) begin errs++; $display("FAIL oneshot_irq got %b want 0", irq); end
    wr(ES_CTRL, 8'h80);
    wr(ES_RELOAD, 8'd1);
    wr(ES_CTRL, 8'h01);
    expQ.push_back(8'h01);
    rd(ES_COUNT);
    got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
    if (got !== exp) begin errs++; $display("FAIL race_count got %h want %h", got, exp); end
    wr(ES_CTRL, 8'h81);
    expQ.push_back(8'h81); expQ.push_back(8'h80);
    for (int i = 0; i < 2; i++) begin
      rd(ES_CTRL);
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL race_ctrl[%0d] got %h want %h", i, got, exp); end
    end
  endtask
`else
  task automatic test_no_timer;
    wr(ES_CTRL, 8'hFF);
    wr(ES_RELOAD, 8'hFF);
    wr(ES_PRESC, 8'h00);
    for (int a = 8; a < 12; a++) begin
      expQ.push_back(8'h00);
      rd(7'(a));
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL notimer_rd[%0h] got %h want %h", a, got, exp); end
    end
    repeat (5) rd(ES_CTRL);
    vecs++;
    if (irq !== 1'b0) begin errs++; $display("FAIL notimer_irq got %b want 0", irq); end
  endtask
`endif
  task automatic test_reset_mid;
    logic found = 1'b0;
    entradas_ext = '0;
    wr(ES_OUT0, 8'h5A);
    wr(ES_OUT3, 8'hC6);
`ifdef ES_TIMER_EN
    wr(ES_PRESC, 8'd3);
    wr(ES_RELOAD, 8'd5);
    wr(ES_CTRL, 8'h07);
    for (int i = 0; i < 40 && !found; i++) begin
      rd(ES_COUNT);
      if (bus.dato_salida_es == 8'd2) found = 1'b1;
    end
    vecs++;
    if (!found) begin errs++; $display("FAIL reach_count2 got never want 02"); end
`else
    repeat (3) rd(ES_OUT0);
`endif
    @(negedge clk);
    reset = 1'b1;
    bus.activar_es = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      expQ.push_back(8'h00);
      rd(7'(a));
      got = bus.dato_salida_es; exp = expQ.pop_front(); vecs++;
      if (got !== exp) begin errs++; $display("FAIL midreset_rd[%0h] got %h want %h", a, got, exp); end
      if (a == 0) begin
        vecs++;
        if (salidas_ext !== 32'h0 || irq !== 1'b0) begin
          errs++; $display("FAIL midreset_pins got salidas=%h irq=%b want 0/0", salidas_ext, irq);
        end
      end
    end
    repeat (30) rd(ES_COUNT);
    vecs++;
    if (irq !== 1'b0 || bus.dato_salida_es !== 8'h00) begin
      errs++; $display("FAIL midreset_noflag got irq=%b count=%h want 0/00", irq, bus.dato_salida_es);
    end
  endtask
  initial begin
    bus.activar_es = 1'b0;
    bus.escribir_es = 1'b0;
    bus.direccion_es = '0;
    bus.dato_entrada_es = '0;
    test_reset;
    test_out_regs;
    test_back_to_back;
    test_inputs;
`ifdef ES_TIMER_EN
    test_timer_auto;
    test_oneshot;
`else
    test_no_timer;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
